// File: rtl/buffer_ctrl_pkg.sv
// Shared definitions for the buffer access arbiter: default sizes,
// the slot index type and the occupancy counter width.
package buffer_ctrl_pkg;

  localparam int N_DEF  = 4;
  localparam int D_DEF  = 4;
  localparam int SLOT_W = 4;  // wide enough for up to 8 writers plus the reader slot

  typedef logic [SLOT_W-1:0] slot_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/buffer_access_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible slot at or after
// the pointer, wrapping from the last slot back to slot 0.
module rr_pick
  import buffer_ctrl_pkg::*;
#(
  parameter int S = N_DEF + 1
) (
  input  logic [S-1:0] elig,
  input  slot_t        ptr,
  output logic         valid,
  output slot_t        pick
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    pick  = '0;
    // Walk from the farthest slot back to the pointer so the nearest eligible slot wins.
    for (int j = S - 1; j >= 0; j--) begin
      int s;
      s = int'(ptr) + j;
      if (s >= S) s = s - S;
      if (elig[s]) begin
        valid = 1'b1;
        pick  = slot_t'(s);
      end
    end
  end

endmodule

// File: rtl/buffer_access_arbiter.sv
// Round-robin arbiter giving N bit-serial writers and one reader exclusive
// access to a D-bit shift buffer, with occupancy tracking and read-protocol check.
module buffer_access_arbiter
  import buffer_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int D = D_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          wr_req,
  input  logic [N-1:0]          wr_data,
  output logic [N-1:0]          wr_gnt,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  output logic                  buf_wr_en,
  output logic                  buf_in,
  output logic                  buf_rd_en,
  input  logic                  rd_valid,
  output logic [cnt_w(D)-1:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  proto_err
);

  localparam int CW = cnt_w(D);
  localparam logic [N-1:0]  WR_ONE  = N'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [N:0]   elig;
  logic [N-1:0] pick_oh;
  logic         pick_valid;
  slot_t        pick;
  slot_t        ptr;
  logic         rd_pend;

  // A slot that was granted last cycle still shows its request; skip it.
  assign elig    = {rd_req & ~empty & ~rd_gnt, wr_req & ~wr_gnt & {N{~full}}};
  assign pick_oh = WR_ONE << pick;

  rr_pick #(.S(N + 1)) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .valid (pick_valid),
    .pick  (pick)
  );

  // NOTE: all state and outputs update with non-blocking assignments so every
  // decision below sees the values from the current cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      wr_gnt    <= '0;
      rd_gnt    <= 1'b0;
      buf_wr_en <= 1'b0;
      buf_in    <= 1'b0;
      buf_rd_en <= 1'b0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      rd_pend   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      wr_gnt    <= '0;
      rd_gnt    <= 1'b0;
      buf_wr_en <= 1'b0;
      buf_in    <= 1'b0;
      buf_rd_en <= 1'b0;
      rd_pend   <= buf_rd_en;
      if (rd_valid && !rd_pend) proto_err <= 1'b1;

      if (pick_valid) begin
        ptr <= (pick == slot_t'(N)) ? '0 : pick + slot_t'(1);
        if (pick == slot_t'(N)) begin
          rd_gnt    <= 1'b1;
          buf_rd_en <= 1'b1;
          count     <= count - CNT_ONE;
          full      <= 1'b0;
          empty     <= (count == CNT_ONE);
        end else begin
          wr_gnt    <= pick_oh;
          buf_wr_en <= 1'b1;
          buf_in    <= |(wr_data & pick_oh);
          count     <= count + CNT_ONE;
          full      <= (count == CW'(D - 1));
          empty     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Self-checking bench for buffer_access_arbiter: a slot-level reference model
// compared every cycle, plus directed scenarios with hand-derived grant orders.
module tb_buffer_access_arbiter;
  import buffer_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int CW = cnt_w(D);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  wr_req = '0, wr_data = '0;
  logic [N-1:0]  wr_gnt;
  logic          rd_req = 1'b0, rd_valid = 1'b0;
  logic          rd_gnt, buf_wr_en, buf_in, buf_rd_en, full, empty, proto_err;
  logic [CW-1:0] count;

  buffer_access_arbiter #(.N(N), .D(D)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .buf_wr_en(buf_wr_en), .buf_in(buf_in),
    .buf_rd_en(buf_rd_en), .rd_valid(rd_valid), .count(count), .full(full),
    .empty(empty), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot-level arbitration from the stated rules.
  int           m_ptr, m_count, m_pick;
  logic [N-1:0] m_wr_gnt;
  logic         m_rd_gnt, m_wr_en, m_in, m_rd_en, m_perr, m_prev_rd;

  function automatic int pick_slot(input int ptr, input int cnt, input logic [N-1:0] wg,
                                   input logic rg, input logic [N-1:0] wreq, input logic rreq);
    for (int j = 0; j <= N; j++) begin
      int s;
      s = (ptr + j) % (N + 1);
      if (s < N) begin
        if (wreq[s] && cnt < D && !wg[s]) return s;
      end else if (rreq && cnt > 0 && !rg) begin
        return s;
      end
    end
    return -1;
  endfunction

  always_comb m_pick = pick_slot(m_ptr, m_count, m_wr_gnt, m_rd_gnt, wr_req, rd_req);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr <= 0; m_count <= 0; m_wr_gnt <= '0; m_rd_gnt <= 1'b0;
      m_wr_en <= 1'b0; m_in <= 1'b0; m_rd_en <= 1'b0; m_perr <= 1'b0; m_prev_rd <= 1'b0;
    end else begin
      m_perr    <= m_perr | (rd_valid & ~m_prev_rd);
      m_prev_rd <= m_rd_en;
      m_wr_gnt  <= '0; m_rd_gnt <= 1'b0; m_wr_en <= 1'b0; m_in <= 1'b0; m_rd_en <= 1'b0;
      if (m_pick >= 0) begin
        m_ptr <= (m_pick + 1) % (N + 1);
        if (m_pick < N) begin
          m_wr_gnt[m_pick] <= 1'b1;
          m_wr_en          <= 1'b1;
          m_in             <= wr_data[m_pick];
          m_count          <= m_count + 1;
        end else begin
          m_rd_gnt <= 1'b1;
          m_rd_en  <= 1'b1;
          m_count  <= m_count - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("wr_gnt", wr_gnt, m_wr_gnt);
    check("rd_gnt", rd_gnt, m_rd_gnt);
    check("buf_wr_en", buf_wr_en, m_wr_en);
    check("buf_in", buf_in, m_in);
    check("buf_rd_en", buf_rd_en, m_rd_en);
    check("count", count, m_count);
    check("full", full, m_count == D);
    check("empty", empty, m_count == 0);
    check("proto_err", proto_err, m_perr);
    check("wr_rd_overlap", buf_wr_en & buf_rd_en, 0);
    check("gnt_onehot", $countones(wr_gnt) <= 1, 1);
  end

  // Grant log for the directed scenarios: slot index, buffer bit, cycle.
  int cyc = 0;
  int g_log[$];
  int b_log[$];
  int c_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (wr_gnt[i]) begin g_log.push_back(i); b_log.push_back(int'(buf_in)); c_log.push_back(cyc); end
    if (rd_gnt) begin g_log.push_back(N); b_log.push_back(0); c_log.push_back(cyc); end
  end

  // Requester / buffer agent.
  bit drop_on_gnt = 0;
  bit raise_rand  = 0;
  bit valid_force = 0;
  bit en_prev     = 0;

  task automatic step();
    @(posedge clk);
    #1;
    rd_valid = valid_force | en_prev;
    en_prev  = buf_rd_en;
    if (drop_on_gnt) begin
      for (int i = 0; i < N; i++) if (wr_gnt[i]) wr_req[i] = 1'b0;
      if (rd_gnt) rd_req = 1'b0;
    end
    if (raise_rand) begin
      for (int i = 0; i < N; i++)
        if (!wr_req[i] && !wr_gnt[i] && $urandom_range(0, 3) == 0) begin
          wr_req[i]  = 1'b1;
          wr_data[i] = 1'($urandom);
        end
      if (!rd_req && !rd_gnt && $urandom_range(0, 2) == 0) rd_req = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wr_req = '0; rd_req = 1'b0; rd_valid = 1'b0; valid_force = 0; en_prev = 0;
    drop_on_gnt = 0; raise_rand = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    g_log.delete(); b_log.delete(); c_log.delete();
  endtask

  task automatic check_log(input string name, input int exp[$]);
    check({name, "_len"}, g_log.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      check(name, (k < g_log.size()) ? g_log[k] : -1, exp[k]);
  endtask

  int fill_seq[4] = '{1, 0, 1, 1};
  int idx;
  bit found;

  initial begin
    // Reset with random inputs: outputs must sit at their reset values.
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      wr_req = N'($urandom); wr_data = N'($urandom); rd_req = 1'($urandom); rd_valid = 1'($urandom);
      @(negedge clk);
      check("rst_wr_gnt", wr_gnt, 0);
      check("rst_rd_gnt", rd_gnt, 0);
      check("rst_buf_wr_en", buf_wr_en, 0);
      check("rst_buf_in", buf_in, 0);
      check("rst_buf_rd_en", buf_rd_en, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_proto_err", proto_err, 0);
    end

    // Fill: writer 0 holds its request, bits 1,0,1,1.
    do_reset();
    idx = 0;
    wr_data[0] = 1'(fill_seq[0]);
    wr_req[0]  = 1'b1;
    repeat (14) begin
      step();
      if (wr_gnt[0] && idx < 3) begin idx++; wr_data[0] = 1'(fill_seq[idx]); end
    end
    check_log("fill_order", '{0, 0, 0, 0});
    for (int k = 0; k < 4; k++) check("fill_buf_in", (k < b_log.size()) ? b_log[k] : -1, fill_seq[k]);
    for (int k = 0; k < 3; k++)
      check("fill_spacing", (k + 1 < c_log.size()) ? c_log[k + 1] - c_log[k] : -1, 2);
    @(negedge clk);
    check("fill_count", count, 4);
    check("fill_full", full, 1);

    // Rotation: all writers request from empty.
    do_reset();
    drop_on_gnt = 1;
    wr_data = N'($urandom);
    wr_req  = '1;
    repeat (8) step();
    check_log("rot_order", '{0, 1, 2, 3});
    wr_req = '1;
    repeat (5) step();
    check("rot_no_more", g_log.size(), 4);
    @(negedge clk);
    check("rot_full", full, 1);

    // Contention: count=2, pointer=3, writers 1 and 3 plus the reader.
    do_reset();
    drop_on_gnt = 1;
    wr_req[1] = 1'b1; repeat (3) step();
    wr_req[2] = 1'b1; repeat (3) step();
    @(negedge clk);
    check("cont_count", count, 2);
    g_log.delete(); b_log.delete(); c_log.delete();
    wr_req[1] = 1'b1; wr_req[3] = 1'b1; rd_req = 1'b1;
    repeat (8) step();
    check_log("cont_order", '{3, N, 1});

    // Empty read: reader blocked until a write lands.
    do_reset();
    drop_on_gnt = 1;
    rd_req = 1'b1;
    repeat (4) step();
    check("empty_no_rd_gnt", g_log.size(), 0);
    wr_req[0] = 1'b1;
    repeat (6) step();
    check_log("empty_order", '{0, N});
    @(negedge clk);
    check("empty_proto_ok", proto_err, 0);

    // Mid-op reset during a grant pulse.
    do_reset();
    wr_data[2] = 1'b1;
    wr_req[2]  = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (wr_gnt[2]) found = 1;
    end
    check("midrst_grant_seen", found, 1);
    rst = 1'b0;
    #1;
    check("midrst_wr_gnt", wr_gnt, 0);
    check("midrst_buf_wr_en", buf_wr_en, 0);
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    en_prev = 0;
    step();
    check("midrst_regrant", wr_gnt, 4'b0100);
    check("midrst_buf_in", buf_in, 1);
    check("midrst_count_after", count, 1);
    wr_req[2] = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    drop_on_gnt = 1;
    raise_rand  = 1;
    repeat (3000) step();
    raise_rand = 0;
    wr_req = '0; rd_req = 1'b0;
    repeat (4) step();

    // Protocol error: rd_valid with no preceding read enable.
    valid_force = 1;
    step();
    valid_force = 0;
    repeat (2) step();
    @(negedge clk);
    check("proto_err_set", proto_err, 1);
    repeat (3) step();
    check("proto_err_sticky", proto_err, 1);
    do_reset();
    @(negedge clk);
    check("proto_err_cleared", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/buffer_access_arbiter.md
BUFFER_ACCESS_ARBITER -- requirements
Module: buffer_access_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of bit-serial write requesters, legal range 1..8.
REQ-002 SHALL have parameter D, default 4: depth in bits of the downstream shift buffer, D >= 2.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port wr_req, input, N bits: per-writer request, held high until granted.
REQ-006 SHALL have port wr_data, input, N bits: per-writer data bit, valid while wr_req is high.
REQ-007 SHALL have port wr_gnt, output, N bits: one-cycle grant pulse, at most one bit high.
REQ-008 SHALL have port rd_req, input, 1 bit: reader request, held high until granted.
REQ-009 SHALL have port rd_gnt, output, 1 bit: one-cycle reader grant pulse.
REQ-010 SHALL have port buf_wr_en, output, 1 bit: buffer shift-in enable.
REQ-011 SHALL have port buf_in, output, 1 bit: bit driven into the buffer.
REQ-012 SHALL have port buf_rd_en, output, 1 bit: buffer read enable.
REQ-013 SHALL have port rd_valid, input, 1 bit: buffer output is valid.
REQ-014 SHALL have port count, output, $clog2(D+1) bits: current occupancy.
REQ-015 SHALL have ports full and empty, outputs, 1 bit each: full = (count == D), empty = (count == 0).

Function
REQ-016 SHALL arbitrate over N+1 slots: slot i is writer i for i < N; slot N is the reader.
REQ-017 Writer slot i SHALL be eligible only when wr_req[i]=1, full=0 and wr_gnt[i]=0 in the current cycle.
REQ-018 Reader slot SHALL be eligible only when rd_req=1, empty=0 and rd_gnt=0 in the current cycle.
REQ-019 SHALL grant at most one slot per clock edge, choosing the first eligible slot at or after the round-robin pointer, with wrap from N to 0.
REQ-020 After a grant to slot k, the pointer SHALL become (k+1) mod (N+1); with no grant, the pointer SHALL hold.
REQ-021 On a writer-k grant decided at edge t, the block SHALL assert wr_gnt[k]=1, buf_wr_en=1 and buf_in=wr_data[k] during cycle t+1 only.
REQ-022 On a reader grant decided at edge t, the block SHALL assert rd_gnt=1 and buf_rd_en=1 during cycle t+1 only.
REQ-023 buf_wr_en and buf_rd_en SHALL never be high in the same cycle.
REQ-024 count SHALL increment at the edge that sets buf_wr_en, and decrement at the edge that sets buf_rd_en.
REQ-025 count SHALL never exceed D or underflow below 0; a full buffer blocks writers and an empty buffer blocks the reader.
REQ-026 rd_valid SHALL be expected exactly one cycle after buf_rd_en.
REQ-027 rd_valid high without a buf_rd_en in the preceding cycle SHALL set the sticky output proto_err, 1 bit, which is cleared only by reset.
REQ-028 All outputs SHALL be registered; no combinational path SHALL exist from inputs to outputs.

Reset
REQ-029 While rst=0, the block SHALL drive wr_gnt=0, rd_gnt=0, buf_wr_en=0, buf_in=0, buf_rd_en=0, count=0, empty=1, full=0, proto_err=0, and pointer=0.
REQ-030 Assertion of rst mid-transfer SHALL abort any pending grant; after release, the first grant SHALL come from the edge following release.

Structure
REQ-031 A shared package buffer_ctrl_pkg SHALL hold the default N and D, the slot-index typedef and the count-width function.
REQ-032 A sub-module rr_pick SHALL compute the round-robin choice from the (N+1)-bit eligible vector and the pointer, and SHALL be purely combinational.

Verification
REQ-033 Reset check: with rst=0 and random inputs, all outputs SHALL equal their REQ-029 values; empty=1.
REQ-034 Fill: writer 0 requests continuously with bits 1,0,1,1 (D=4) -> four wr_gnt[0] pulses on alternate cycles with buf_in=1,0,1,1, count=4 and full=1; a fifth request SHALL see no grant.
REQ-035 Rotation: all four writers request from the empty state -> grants in the order 0,1,2,3, then full=1 and no further grants.
REQ-036 Contention: count=2, writers 1 and 3 plus the reader all request, pointer=3 -> grant order is writer 3, reader, writer 1, and buf_wr_en/buf_rd_en are never coincident.
REQ-037 Empty read: rd_req=1 with count=0 -> no rd_gnt; after one write, rd_gnt follows and rd_valid is checked one cycle after buf_rd_en.
REQ-038 Mid-op reset: pull rst low during a wr_gnt pulse -> outputs clear immediately, count=0, and the request is regranted after release.
